// File: rtl/bringup_driver.sv
// bringup_driver: programmable pin toggler that exercises a far-end activity sensor.
// Burst mode (mode 3 bursts, GAP state, burst/gap counters, done_o) is built only when
// BRINGUP_DRIVER_BURST_EN is defined; otherwise mode 3 toggles continuously like mode 2.
module bringup_driver #(
    parameter int DIV_BITS   = 16,
    parameter int COUNT_BITS = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [1:0]            mode_i,
    input  logic [DIV_BITS-1:0]   half_period_i,
    input  logic [COUNT_BITS-1:0] burst_len_i,
    input  logic [COUNT_BITS-1:0] gap_len_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic                  pin_o,
    output logic                  busy_o,
    output logic                  done_o
);
`ifdef BRINGUP_DRIVER_BURST_EN
    typedef enum logic [1:0] {IDLE, TOGGLE, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, TOGGLE} state_t;
`endif
    state_t              state_q, state_d;
    logic                pin_q, pin_d, busy_q, busy_d, done_q, done_d;
    logic [DIV_BITS-1:0] div_q, div_d, h_q, h_d, h_eff;
    logic                tick, start_ok;
    assign start_ok = start_i && !stop_i && mode_i[1];
    assign h_eff    = (half_period_i == '0) ? DIV_BITS'(1) : half_period_i;
    assign tick     = (div_q == '0);
`ifdef BRINGUP_DRIVER_BURST_EN
    logic                  burst_q, burst_d, start_zero, burst_end, gap_end;
    logic [COUNT_BITS-1:0] blen_q, blen_d, glen_q, glen_d, tcnt_q, tcnt_d, gcnt_q, gcnt_d;
    assign start_zero = mode_i[0] && (burst_len_i == '0);
    assign burst_end  = burst_q && tick && pin_q && (tcnt_q + COUNT_BITS'(1) == blen_q);
    assign gap_end    = tick && (gcnt_q + COUNT_BITS'(1) == glen_q);
`else
    logic unused_burst;
    assign unused_burst = ^{burst_len_i, gap_len_i};
`endif

    // state and datapath registers, synchronous active-low reset clears everything
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div_q   <= '0;
            h_q     <= '0;
`ifdef BRINGUP_DRIVER_BURST_EN
            burst_q <= 1'b0;
            blen_q  <= '0;
            glen_q  <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pin_q   <= pin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            div_q   <= div_d;
            h_q     <= h_d;
`ifdef BRINGUP_DRIVER_BURST_EN
            burst_q <= burst_d;
            blen_q  <= blen_d;
            glen_q  <= glen_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
`endif
        end
    end

    // next state: zero-length burst/gap phases are skipped on the edge that would enter them; stop wins
    always_comb begin
`ifdef BRINGUP_DRIVER_BURST_EN
        case (state_q)
            IDLE:    state_d = !start_ok ? IDLE : !start_zero ? TOGGLE : (gap_len_i == '0) ? IDLE : GAP;
            TOGGLE:  state_d = !burst_end ? TOGGLE : (glen_q == '0) ? IDLE : GAP;
            GAP:     state_d = gap_end ? IDLE : GAP;
            default: state_d = IDLE;
        endcase
`else
        state_d = (state_q == IDLE && !start_ok) ? IDLE : TOGGLE;
`endif
        if (stop_i) state_d = IDLE;
    end

    // next outputs and counters; the last burst toggle is a falling one so pin is already low entering GAP
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = 1'b0;
        pin_d  = !stop_i && (state_q == TOGGLE) && (tick ^ pin_q);
        div_d  = tick ? h_q - DIV_BITS'(1) : div_q - DIV_BITS'(1);
        h_d    = h_q;
`ifdef BRINGUP_DRIVER_BURST_EN
        burst_d = burst_q;
        blen_d  = blen_q;
        glen_d  = glen_q;
        tcnt_d  = (state_q == TOGGLE && burst_q && tick && pin_q) ? tcnt_q + COUNT_BITS'(1) : tcnt_q;
        gcnt_d  = (state_q == GAP && tick) ? gcnt_q + COUNT_BITS'(1) : gcnt_q;
        done_d  = !stop_i && ((state_q == TOGGLE && burst_end && glen_q == '0) || (state_q == GAP && gap_end));
`endif
        if (state_q == IDLE) begin
            pin_d = (mode_i == 2'd1);
            div_d = start_ok ? h_eff - DIV_BITS'(1) : div_q;
            h_d   = start_ok ? h_eff : h_q;
`ifdef BRINGUP_DRIVER_BURST_EN
            burst_d = start_ok ? mode_i[0] : burst_q;
            blen_d  = start_ok ? burst_len_i : blen_q;
            glen_d  = start_ok ? gap_len_i : glen_q;
            tcnt_d  = start_ok ? '0 : tcnt_q;
            gcnt_d  = start_ok ? '0 : gcnt_q;
            done_d  = start_ok && start_zero && (gap_len_i == '0);
`endif
        end
    end

    assign pin_o  = pin_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

// File: tb/tb_bringup_driver.sv
// tb_bringup_driver: directed bench for bringup_driver with hand-computed expectations.
module tb_bringup_driver;
    logic        clock = 1'b0, reset_n = 1'b0, start_i = 1'b0, stop_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [15:0] half_period_i = '0;
    logic [7:0]  burst_len_i = '0, gap_len_i = '0;
    logic        pin_o, busy_o, done_o;
    logic        pin_last = 1'b0;
    int          cyc = 0, toggles = 0, last_tog = 0, dones = 0;
    int          checks = 0, errors = 0;
    int          s, t0, d0;

    bringup_driver #(.DIV_BITS(16), .COUNT_BITS(8)) dut (
        .clock(clock), .reset_n(reset_n), .mode_i(mode_i), .half_period_i(half_period_i),
        .burst_len_i(burst_len_i), .gap_len_i(gap_len_i), .start_i(start_i), .stop_i(stop_i),
        .pin_o(pin_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (pin_o !== pin_last) begin
            toggles  <= toggles + 1;
            last_tog <= cyc;
        end
        pin_last <= pin_o;
        if (done_o === 1'b1) dones <= dones + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic to_edge(input int n);
        while (cyc < n) @(negedge clock);
        #1;
    endtask

    initial begin
        to_edge(2);
        check("rst_pin", pin_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        reset_n = 1'b1;
        mode_i  = 2'd1;
        to_edge(3);
        check("idle_high", pin_o, 1);
        mode_i = 2'd0;
        to_edge(4);
        check("idle_low", pin_o, 0);
        mode_i  = 2'd2;
        start_i = 1'b1;
        stop_i  = 1'b1;
        to_edge(5);
        check("start_stop_busy", busy_o, 0);
        check("start_stop_pin", pin_o, 0);
        stop_i        = 1'b0;
        half_period_i = 16'd0;
        t0 = toggles;
        d0 = dones;
        s  = cyc + 1;
        to_edge(s);
        start_i = 1'b0;
        check("cont_busy", busy_o, 1);
        check("cont_pin0", pin_o, 0);
        to_edge(s + 1);
        check("cont_pin1", pin_o, 1);
        start_i       = 1'b1;
        half_period_i = 16'd5;
        to_edge(s + 2);
        start_i = 1'b0;
        check("cont_pin2", pin_o, 0);
        to_edge(s + 3);
        check("cont_busy_restart_ignored", pin_o, 1);
        to_edge(s + 10);
        check("cont_toggles", toggles - t0, 10);
        check("cont_pin10", pin_o, 0);
        stop_i = 1'b1;
        to_edge(s + 11);
        stop_i = 1'b0;
        check("stop_pin", pin_o, 0);
        check("stop_busy", busy_o, 0);
        check("stop_no_done", dones - d0, 0);
        half_period_i = 16'd2;
        start_i       = 1'b1;
        s = cyc + 1;
        to_edge(s);
        start_i = 1'b0;
        check("rr_busy", busy_o, 1);
        to_edge(s + 2);
        check("rr_pin", pin_o, 1);
        reset_n = 1'b0;
        to_edge(s + 3);
        check("rr_rst_pin", pin_o, 0);
        check("rr_rst_busy", busy_o, 0);
        check("rr_rst_done", done_o, 0);
        to_edge(s + 5);
        check("rr_rst_held", busy_o, 0);
        reset_n = 1'b1;
        start_i = 1'b1;
        s = s + 6;
        to_edge(s);
        start_i = 1'b0;
        check("rr_release_start", busy_o, 1);
        to_edge(s + 1);
        check("rr_pin_pre", pin_o, 0);
        to_edge(s + 2);
        check("rr_pin_tog", pin_o, 1);
        stop_i = 1'b1;
        to_edge(s + 3);
        stop_i = 1'b0;
        check("rr_stop_busy", busy_o, 0);
`ifdef BRINGUP_DRIVER_BURST_EN
        mode_i        = 2'd3;
        half_period_i = 16'd4;
        burst_len_i   = 8'd3;
        gap_len_i     = 8'd2;
        start_i       = 1'b1;
        t0 = toggles;
        d0 = dones;
        s  = cyc + 1;
        to_edge(s);
        start_i       = 1'b0;
        mode_i        = 2'd2;
        burst_len_i   = 8'd9;
        gap_len_i     = 8'd9;
        half_period_i = 16'd1;
        check("burst_busy", busy_o, 1);
        check("burst_pin0", pin_o, 0);
        to_edge(s + 3);
        check("burst_pin3", pin_o, 0);
        to_edge(s + 4);
        check("burst_pin4", pin_o, 1);
        to_edge(s + 24);
        check("burst_toggles", toggles - t0, 6);
        check("burst_last_tog", last_tog, s + 24);
        check("burst_pin_end", pin_o, 0);
        check("burst_busy_gap", busy_o, 1);
        to_edge(s + 27);
        start_i = 1'b1;
        to_edge(s + 28);
        start_i = 1'b0;
        check("gap_start_busy", busy_o, 1);
        to_edge(s + 31);
        check("gap_busy31", busy_o, 1);
        check("gap_done31", done_o, 0);
        to_edge(s + 32);
        check("burst_done", done_o, 1);
        check("burst_busy_fall", busy_o, 0);
        check("burst_pin_done", pin_o, 0);
        to_edge(s + 33);
        check("burst_done_clear", done_o, 0);
        check("burst_done_count", dones - d0, 1);
        check("gap_start_ignored", busy_o, 0);
        check("burst_toggles_final", toggles - t0, 6);
        mode_i        = 2'd3;
        half_period_i = 16'd3;
        burst_len_i   = 8'd0;
        gap_len_i     = 8'd0;
        start_i       = 1'b1;
        t0 = toggles;
        s  = cyc + 1;
        to_edge(s);
        start_i = 1'b0;
        check("zero_done", done_o, 1);
        check("zero_busy", busy_o, 0);
        check("zero_pin", pin_o, 0);
        to_edge(s + 1);
        check("zero_done_clear", done_o, 0);
        to_edge(s + 6);
        check("zero_toggles", toggles - t0, 0);
        burst_len_i = 8'd255;
        gap_len_i   = 8'd1;
        start_i     = 1'b1;
        t0 = toggles;
        s  = cyc + 1;
        to_edge(s);
        start_i = 1'b0;
        to_edge(s + 1530);
        check("max_toggles", toggles - t0, 510);
        check("max_last_tog", last_tog, s + 1530);
        check("max_busy", busy_o, 1);
        to_edge(s + 1532);
        check("max_done_early", done_o, 0);
        to_edge(s + 1533);
        check("max_done", done_o, 1);
        check("max_busy_fall", busy_o, 0);
`else
        mode_i        = 2'd3;
        half_period_i = 16'd2;
        burst_len_i   = 8'd1;
        gap_len_i     = 8'd0;
        start_i       = 1'b1;
        t0 = toggles;
        d0 = dones;
        s  = cyc + 1;
        to_edge(s);
        start_i = 1'b0;
        check("m3_busy", busy_o, 1);
        to_edge(s + 2);
        check("m3_pin2", pin_o, 1);
        to_edge(s + 100);
        check("m3_toggles", toggles - t0, 50);
        check("m3_busy_end", busy_o, 1);
        check("m3_no_done", dones - d0, 0);
        stop_i = 1'b1;
        to_edge(s + 101);
        stop_i = 1'b0;
        check("m3_stop_busy", busy_o, 0);
        check("m3_stop_pin", pin_o, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
